// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback buffer placed in front of the register
// bank write port. Requests enter through a valid/ready handshake. One entry
// leaves per cycle into a registered RegWrite/sel/data beat.
// Optional macro WB_FWD_EN adds snoop forwarding of pending writes to the two
// bank read selectors. When it is undefined, the forwarding outputs are tied
// to zero.
module reg_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        sel,
  output logic [DATA_W-1:0]        data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        selA,
  input  logic [ADDR_W-1:0]        selB,
  output logic                     fwdA_hit,
  output logic [DATA_W-1:0]        fwdA_data,
  output logic                     fwdB_hit,
  output logic [DATA_W-1:0]        fwdB_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Entry storage. It has no reset because the contents are only meaningful
  // below count.
  logic [ADDR_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              regwrite_reg;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] data_reg;

  logic push;
  logic pop;

  // Ready depends only on registered occupancy. A full queue never accepts,
  // even in a cycle that pops.
  assign in_ready = (count_reg < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = (count_reg != '0) && drain_en;

  assign RegWrite = regwrite_reg;
  assign sel      = sel_reg;
  assign data     = data_reg;
  assign count    = count_reg;

  // Write an accepted request into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg]  <= in_reg;
      mem_data[wr_ptr_reg] <= in_data;
    end
  end

  // Update the pointers and occupancy. Reset discards any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Move the head entry into the bank write beat. sel/data hold between beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_reg <= 1'b0;
      sel_reg      <= '0;
      data_reg     <= '0;
    end else if (pop) begin
      regwrite_reg <= 1'b1;
      sel_reg      <= mem_reg[rd_ptr_reg];
      data_reg     <= mem_data[rd_ptr_reg];
    end else begin
      regwrite_reg <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  // A slot is live when its age (distance from the head) is below count.
  logic [DEPTH-1:0] slot_live;
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] age;
    assign age         = PTR_W'(gi) - rd_ptr_reg;
    assign slot_live[gi] = ({1'b0, age} < count_reg);
    assign match_a[gi]   = slot_live[gi] && (mem_reg[gi] == selA);
    assign match_b[gi]   = slot_live[gi] && (mem_reg[gi] == selB);
  end

  // Pick the youngest pending value. The search starts at the output beat and
  // then walks the FIFO from oldest to newest, so later matches override earlier ones.
  always_comb begin : fwd_pick
    logic [PTR_W-1:0] idx;
    idx       = '0;
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    if (regwrite_reg && (sel_reg == selA)) begin
      fwdA_hit  = 1'b1;
      fwdA_data = data_reg;
    end
    if (regwrite_reg && (sel_reg == selB)) begin
      fwdB_hit  = 1'b1;
      fwdB_data = data_reg;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PTR_W'(k);
      if (match_a[idx]) begin
        fwdA_hit  = 1'b1;
        fwdA_data = mem_data[idx];
      end
      if (match_b[idx]) begin
        fwdB_hit  = 1'b1;
        fwdB_data = mem_data[idx];
      end
    end
  end
`else
  // Forwarding is disabled, so the read selectors are only observed here.
  logic unused_sel;
  assign unused_sel = ^{selA, selB};

  assign fwdA_hit  = 1'b0;
  assign fwdA_data = '0;
  assign fwdB_hit  = 1'b0;
  assign fwdB_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Testbench for reg_wb_queue. It runs directed scenarios followed by
// randomized traffic. Every cycle is checked against a queue-based reference
// model. Forwarding expectations follow the WB_FWD_EN macro.
module tb_reg_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_en = 1'b0;
  logic              RegWrite;
  logic [ADDR_W-1:0] sel;
  logic [DATA_W-1:0] data;
  logic [2:0]        count;
  logic [ADDR_W-1:0] selA = '0;
  logic [ADDR_W-1:0] selB = '0;
  logic              fwdA_hit;
  logic [DATA_W-1:0] fwdA_data;
  logic              fwdB_hit;
  logic [DATA_W-1:0] fwdB_data;

  reg_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .RegWrite(RegWrite), .sel(sel), .data(data), .count(count),
    .selA(selA), .selB(selB),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
    .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes kept as a plain queue, plus the last beat.
  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  logic              exp_rw = 1'b0;
  logic [ADDR_W-1:0] exp_sel = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              last_push = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the queue rules to the inputs present at the rising edge.
  task automatic model_update();
    bit do_pop;
    bit do_push;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      exp_rw    = 1'b0;
      exp_sel   = '0;
      exp_data  = '0;
      last_push = 1'b0;
      return;
    end
    do_pop  = (q.size() > 0) && drain_en;
    do_push = in_valid && (q.size() < DEPTH);
    if (do_pop) begin
      e        = q.pop_front();
      exp_rw   = 1'b1;
      exp_sel  = e.r;
      exp_data = e.d;
      $display("beat  reg=%0d data=%08h", e.r, e.d);
    end else begin
      exp_rw = 1'b0;
    end
    if (do_push) begin
      q.push_back('{r: in_reg, d: in_data});
      $display("push  reg=%0d data=%08h", in_reg, in_data);
    end
    last_push = do_push;
  endtask

  // The newest pending write to s wins. If none is pending, the current output beat is used.
  task automatic fwd_model(input logic [ADDR_W-1:0] s, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_FWD_EN
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].r == s) begin
        hit = 1'b1;
        d   = q[i].d;
        return;
      end
    end
    if (exp_rw && exp_sel == s) begin
      hit = 1'b1;
      d   = exp_data;
    end
`endif
  endtask

  task automatic check_outputs();
    logic              h;
    logic [DATA_W-1:0] d;
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("count",    64'(count),    64'(q.size()));
    check("RegWrite", 64'(RegWrite), 64'(exp_rw));
    check("sel",      64'(sel),      64'(exp_sel));
    check("data",     64'(data),     64'(exp_data));
    fwd_model(selA, h, d);
    check("fwdA_hit", 64'(fwdA_hit), 64'(h));
`ifdef WB_FWD_EN
    if (h) check("fwdA_data", 64'(fwdA_data), 64'(d));
`else
    check("fwdA_data", 64'(fwdA_data), 64'(d));
`endif
    fwd_model(selB, h, d);
    check("fwdB_hit", 64'(fwdB_hit), 64'(h));
`ifdef WB_FWD_EN
    if (h) check("fwdB_data", 64'(fwdB_data), 64'(d));
`else
    check("fwdB_data", 64'(fwdB_data), 64'(d));
`endif
  endtask

  // Advance one clock cycle, update the model at the edge, and check on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  // Present a request and hold it until it is accepted. The wait is bounded.
  task automatic send(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_push) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: reg %0d not accepted within 20 cycles", r);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // 1. Reset, then idle with drain enabled.
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n    = 1'b1;
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("t1_ready", 64'(in_ready), 64'd1);

    // 2. Single write produces a one-beat strobe one cycle later.
    send(5'b10010, 32'h9FFF_FFFF);
    cycle();
    check("t2_rw",   64'(RegWrite), 64'd1);
    check("t2_sel",  64'(sel),      64'h12);
    check("t2_data", 64'(data),     64'h9FFF_FFFF);
    cycle();
    check("t2_rw_drop", 64'(RegWrite), 64'd0);
    check("t2_count",   64'(count),    64'd0);

    // 3. Fill the queue, then apply backpressure on the fifth request.
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) send(ADDR_W'(i), 32'hA000_0000 + i);
    in_valid = 1'b1;
    in_reg   = 5'd5;
    in_data  = 32'hA000_0005;
    cycle();
    cycle();
    check("t3_full_count", 64'(count),    64'd4);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    drain_en = 1'b1;
    send(5'd5, 32'hA000_0005);
    for (int i = 0; i < 6; i++) cycle();

    // 4. Stream back-to-back requests so the pointers wrap.
    for (int i = 0; i < 10; i++) begin
      send(ADDR_W'(i + 8), 32'hB000_0000 + i);
      check("t4_count_le1", 64'(count <= 1), 64'd1);
    end
    for (int i = 0; i < 3; i++) cycle();

    // 5. Forwarding returns the youngest matching entry.
    drain_en = 1'b0;
    send(5'd26, 32'h11);
    send(5'd22, 32'h22);
    send(5'd26, 32'h33);
    selA = 5'd26;
    selB = 5'd22;
    cycle();
`ifdef WB_FWD_EN
    check("t5_a_hit",  64'(fwdA_hit),  64'd1);
    check("t5_a_data", 64'(fwdA_data), 64'h33);
    check("t5_b_hit",  64'(fwdB_hit),  64'd1);
    check("t5_b_data", 64'(fwdB_data), 64'h22);
`else
    check("t5_a_hit_off", 64'(fwdA_hit), 64'd0);
    check("t5_b_hit_off", 64'(fwdB_hit), 64'd0);
`endif
    selA = 5'd3;
    cycle();
    check("t5_a_miss", 64'(fwdA_hit), 64'd0);
    drain_en = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // 6. Reset in the middle of a drain discards the pending entries.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) send(ADDR_W'(i + 1), 32'hC000_0000 + i);
    drain_en = 1'b1;
    cycle();
    check("t6_pre_rw",    64'(RegWrite), 64'd1);
    check("t6_pre_count", 64'(count),    64'd3);
    rst_n = 1'b0;
    cycle();
    check("t6_count", 64'(count),    64'd0);
    check("t6_rw",    64'(RegWrite), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t6_no_write", 64'(RegWrite), 64'd0);
    end

    // Randomized traffic with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 1) == 1);
      drain_en = ($urandom_range(0, 9) < 7);
      in_reg   = ADDR_W'($urandom_range(0, 7));
      in_data  = $urandom;
      selA     = ADDR_W'($urandom_range(0, 7));
      selB     = ADDR_W'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
